// File: rtl/run_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : run_ctrl_pkg
// Description : Shared definitions for the run controller. Holds the
//               controller state encoding, the default port widths and a
//               small helper that identifies the states that accept image
//               beats.
// Revision    : 1.0  initial release
// ============================================================================
package run_ctrl_pkg;

  // Default widths used by the controller and its dump sequencer.
  localparam int c_DEF_DATA_W     = 32;
  localparam int c_DEF_MEM_AW     = 10;
  localparam int c_DEF_NREGS      = 32;
  localparam int c_DEF_REG_AW     = 5;
  localparam int c_DEF_CNT_W      = 16;
  localparam int c_DEF_RESULT_REG = 9;

  // Controller state encoding. Kept as plain sized constants so the same
  // encoding can be shared with older tooling that expects raw vectors.
  localparam int         c_STATE_W  = 3;
  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_LOAD  = 3'd1;
  localparam logic [2:0] c_ST_RUN   = 3'd2;
  localparam logic [2:0] c_ST_FETCH = 3'd3;
  localparam logic [2:0] c_ST_DUMP  = 3'd4;
  localparam logic [2:0] c_ST_DONE  = 3'd5;

  // True in the states where the image port is open (IDLE, LOAD, DONE).
  function automatic logic accepts_load(input logic [2:0] st);
    return (st == c_ST_IDLE) || (st == c_ST_LOAD) || (st == c_ST_DONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_dump_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rf_dump_seq
// Description : Register-file dump sequencer. Walks the register index from
//               0 to NREGS-1, presenting each index on the register-file read
//               port during FETCH, capturing the read data at the FETCH->DUMP
//               boundary and offering it on a ready/valid port during DUMP.
// Ports       : clk_i          clock, rising edge
//               rst_i          asynchronous active-high reset
//               go_i           restart the walk at index 0
//               fetch_i        controller is in FETCH
//               dump_i         controller is in DUMP
//               rf_rd_addr_o   register-file read address
//               rf_rd_data_i   register-file read data
//               dump_valid_o   dump beat valid
//               dump_ready_i   dump beat accepted by the sink
//               dump_idx_o     index of the offered register
//               dump_data_o    value of the offered register
//               beat_o         handshake completed this cycle
//               last_done_o    handshake of the final register this cycle
// Revision    : 1.0  initial release
// ============================================================================
module rf_dump_seq
  import run_ctrl_pkg::*;
#(
  parameter int DATA_W = c_DEF_DATA_W,
  parameter int NREGS  = c_DEF_NREGS,
  parameter int REG_AW = c_DEF_REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go_i,
  input  logic              fetch_i,
  input  logic              dump_i,
  output logic [REG_AW-1:0] rf_rd_addr_o,
  input  logic [DATA_W-1:0] rf_rd_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [REG_AW-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              beat_o,
  output logic              last_done_o
);

  localparam logic [REG_AW-1:0] c_LAST_IDX = REG_AW'(NREGS - 1);

  logic [REG_AW-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              w_beat;
  logic              w_at_last;

  assign w_beat    = dump_i & dump_ready_i;
  assign w_at_last = (idx_q == c_LAST_IDX);

  always_comb begin
    idx_d  = idx_q;
    data_d = data_q;
    if (go_i) begin
      idx_d = '0;
    end else if (w_beat && !w_at_last) begin
      idx_d = idx_q + 1'b1;
    end
    // The read port returns the addressed word within the FETCH cycle; it
    // is captured here so dump_data stays frozen for however long DUMP
    // waits on dump_ready.
    if (fetch_i) begin
      data_d = rf_rd_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      idx_q  <= idx_d;
      data_q <= data_d;
    end
  end

  // Outputs are qualified by state so nothing leaks onto the ports outside
  // the dump window; dump_valid has no path from dump_ready.
  assign rf_rd_addr_o = fetch_i ? idx_q  : '0;
  assign dump_valid_o = dump_i;
  assign dump_idx_o   = dump_i  ? idx_q  : '0;
  assign dump_data_o  = dump_i  ? data_q : '0;
  assign beat_o       = w_beat;
  assign last_done_o  = w_beat & w_at_last;

endmodule
`default_nettype wire

// File: rtl/run_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : run_controller
// Description : Load / run / dump controller for the RISC-V core. Streams a
//               program image into main memory while the core is held in
//               reset, runs the core under an optional cycle budget, stops on
//               halt or budget expiry, then serialises the register file out
//               over a ready/valid port.
// Ports       : clk_i, rst_i                     clock / async reset
//               load_valid_i, load_ready_o        image beat handshake
//               load_addr_i, load_data_i          image beat address / word
//               load_last_i                       final beat of the image
//               start_i                           single-cycle run request
//               max_cycles_i                      run budget, 0 = unlimited
//               core_halt_i                       core completion
//               wb_valid_i, wb_rd_i, wb_data_i    core register writeback
//               core_reset_o                      reset to the core
//               mem_we_o, mem_addr_o, mem_wdata_o memory write port
//               rf_rd_addr_o, rf_rd_data_i        register-file read port
//               dump_valid_o, dump_ready_i        dump handshake
//               dump_idx_o, dump_data_o           dump beat contents
//               done_o                            dump complete
//               timed_out_o                       run ended by the budget
//               cycles_o                          RUN cycles elapsed
//               result_o                          last value written to
//                                                 RESULT_REG
// Revision    : 1.0  initial release
// ============================================================================
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int DATA_W     = c_DEF_DATA_W,
  parameter int MEM_AW     = c_DEF_MEM_AW,
  parameter int NREGS      = c_DEF_NREGS,
  parameter int REG_AW     = c_DEF_REG_AW,
  parameter int CNT_W      = c_DEF_CNT_W,
  parameter int RESULT_REG = c_DEF_RESULT_REG
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // image load port
  input  logic              load_valid_i,
  output logic              load_ready_o,
  input  logic [MEM_AW-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              load_last_i,
  // run control
  input  logic              start_i,
  input  logic [CNT_W-1:0]  max_cycles_i,
  input  logic              core_halt_i,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              core_reset_o,
  // memory write port
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  // register-file read port
  output logic [REG_AW-1:0] rf_rd_addr_o,
  input  logic [DATA_W-1:0] rf_rd_data_i,
  // dump port
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [REG_AW-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  // status
  output logic              done_o,
  output logic              timed_out_o,
  output logic [CNT_W-1:0]  cycles_o,
  output logic [DATA_W-1:0] result_o
);

  localparam logic [REG_AW-1:0] c_RESULT_IDX = REG_AW'(RESULT_REG);

  logic [c_STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]     cycles_q, cycles_d;
  logic                 timed_out_q, timed_out_d;
  logic [DATA_W-1:0]    result_q, result_d;

  logic                 w_load_fire;
  logic                 w_run_enter;
  logic                 w_run_exit;
  logic                 w_budget_hit;
  logic [CNT_W-1:0]     w_cycles_inc;
  logic                 w_in_fetch;
  logic                 w_in_dump;
  logic                 w_dump_beat;
  logic                 w_last_done;

  // --------------------------------------------------------------------------
  // Image load: beats are written straight through to memory in the cycle
  // they are accepted.
  // --------------------------------------------------------------------------
  assign load_ready_o = accepts_load(state_q);
  assign w_load_fire  = load_valid_i & load_ready_o;
  assign mem_we_o     = w_load_fire;
  assign mem_addr_o   = w_load_fire ? load_addr_i : '0;
  assign mem_wdata_o  = w_load_fire ? load_data_i : '0;

  // The core only runs in RUN; FETCH/DUMP keep it frozen so the register
  // file is stable while it is read out.
  assign core_reset_o = (state_q != c_ST_RUN);

  // Budget compare looks one cycle ahead so the core gets exactly
  // max_cycles RUN cycles. The increment only wraps at all-ones, which can
  // never match because a zero budget disables the compare.
  assign w_cycles_inc = cycles_q + 1'b1;
  assign w_budget_hit = (max_cycles_i != '0) && (w_cycles_inc == max_cycles_i);

  // --------------------------------------------------------------------------
  // Controller state machine
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE, c_ST_DONE: begin
        // A beat takes priority over a coincident start.
        if (w_load_fire) begin
          state_d = load_last_i ? c_ST_IDLE : c_ST_LOAD;
        end else if (start_i) begin
          state_d = c_ST_RUN;
        end
      end
      c_ST_LOAD: begin
        if (w_load_fire && load_last_i) begin
          state_d = c_ST_IDLE;
        end
      end
      c_ST_RUN: begin
        if (core_halt_i || w_budget_hit) begin
          state_d = c_ST_FETCH;
        end
      end
      c_ST_FETCH: begin
        state_d = c_ST_DUMP;
      end
      c_ST_DUMP: begin
        if (w_dump_beat) begin
          state_d = w_last_done ? c_ST_DONE : c_ST_FETCH;
        end
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase
  end

  assign w_run_enter = (state_q != c_ST_RUN) && (state_d == c_ST_RUN);
  assign w_run_exit  = (state_q == c_ST_RUN) && (state_d == c_ST_FETCH);
  assign w_in_fetch  = (state_q == c_ST_FETCH);
  assign w_in_dump   = (state_q == c_ST_DUMP);

  // --------------------------------------------------------------------------
  // Run statistics: cycle count, timeout flag and captured result. All are
  // cleared on RUN entry and otherwise held outside RUN.
  // --------------------------------------------------------------------------
  always_comb begin
    cycles_d    = cycles_q;
    timed_out_d = timed_out_q;
    result_d    = result_q;
    if (w_run_enter) begin
      cycles_d    = '0;
      timed_out_d = 1'b0;
      result_d    = '0;
    end else if (state_q == c_ST_RUN) begin
      if (cycles_q != '1) begin
        cycles_d = w_cycles_inc;
      end
      if (wb_valid_i && (wb_rd_i == c_RESULT_IDX)) begin
        result_d = wb_data_i;
      end
      // Halt wins over a coincident budget expiry.
      if (w_run_exit) begin
        timed_out_d = ~core_halt_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= c_ST_IDLE;
      cycles_q    <= '0;
      timed_out_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      cycles_q    <= cycles_d;
      timed_out_q <= timed_out_d;
      result_q    <= result_d;
    end
  end

  assign done_o      = (state_q == c_ST_DONE);
  assign timed_out_o = timed_out_q;
  assign cycles_o    = cycles_q;
  assign result_o    = result_q;

  // --------------------------------------------------------------------------
  // Register-file dump
  // --------------------------------------------------------------------------
  rf_dump_seq #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .REG_AW (REG_AW)
  ) u_dump (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .go_i         (w_run_exit),
    .fetch_i      (w_in_fetch),
    .dump_i       (w_in_dump),
    .rf_rd_addr_o (rf_rd_addr_o),
    .rf_rd_data_i (rf_rd_data_i),
    .dump_valid_o (dump_valid_o),
    .dump_ready_i (dump_ready_i),
    .dump_idx_o   (dump_idx_o),
    .dump_data_o  (dump_data_o),
    .beat_o       (w_dump_beat),
    .last_done_o  (w_last_done)
  );

endmodule
`default_nettype wire
